// File: rtl/hilo_mult_unit.sv
// HI/LO register pair with an iterative radix-2 shift-add 32x32 multiplier.
// MULT/MULTU take 33 clocks start-to-result; MTHI/MTLO write HI/LO directly when idle.
module hilo_mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_neg;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_start_accept;
    logic               w_mt_allowed;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_product;

    // Handshake: start is a level request honoured only on an edge where the
    // unit is idle (busy=0); there is no queuing, so a start seen while busy
    // is dropped. done pulses for one cycle when HI/LO take the new product.
    assign w_start_accept = (r_state == S_IDLE) && start;
    assign w_mt_allowed   = (r_state == S_IDLE) && !start;

    // The most negative value's magnitude still fits in WIDTH unsigned bits.
    assign w_mag_a = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign w_mag_b = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

    assign w_addend  = r_mplier[0] ? r_mcand : '0;
    assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
    assign w_product = r_neg ? ({(2*WIDTH){1'b0}} - r_acc) : r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == LAST_ITER) begin
                    w_next_state = S_FINISH;
                end
            end
            S_FINISH: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
        end else if (w_start_accept) begin
            r_mcand  <= w_mag_a;
            r_mplier <= w_mag_b;
            r_acc    <= '0;
            r_neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_cnt    <= '0;
        end else if (r_state == S_RUN) begin
            // The carry out of the upper-half add shifts into the MSB.
            r_acc    <= {w_sum, r_acc[WIDTH-1:1]};
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == S_FINISH);
            if (r_state == S_FINISH) begin
                r_hi <= w_product[2*WIDTH-1:WIDTH];
                r_lo <= w_product[WIDTH-1:0];
            end else if (w_mt_allowed) begin
                if (mthi) begin
                    r_hi <= wdata;
                end
                if (mtlo) begin
                    r_lo <= wdata;
                end
            end
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign hi        = r_hi;
    assign lo        = r_lo;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Directed bench for hilo_mult_unit: reset, MULT/MULTU corners, MTHI/MTLO and
// start collisions, each scenario checked against hand-computed values.
module tb_hilo_mult_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  dbg_state;

    int vectors;
    int miscompares;

    // bench-side copy of what HI/LO should hold
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    hilo_mult_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .mthi      (mthi),
        .mtlo      (mtlo),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 plain, 1 pulse mtlo mid-run, 2 hold start and change operands
    // during the run (to 7x6 MULTU), 3 assert mthi together with start.
    task automatic run_mul(input string name, input logic sgn,
                           input logic [31:0] av, input logic [31:0] bv,
                           input logic [31:0] eh, input logic [31:0] el,
                           input int mode);
        int lat;
        lat = 0;
        start = 1'b1;
        is_signed = sgn;
        a = av;
        b = bv;
        if (mode == 3) begin
            mthi = 1'b1;
            wdata = 32'h1234_5678;
        end
        tick();
        mthi = 1'b0;
        if (mode == 2) begin
            is_signed = 1'b0;
            a = 32'd7;
            b = 32'd6;
        end else begin
            start = 1'b0;
        end
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s busy_after_start: got %b want 1", name, busy);
        end
        for (int i = 1; i <= 40; i++) begin
            if (mode == 1 && i == 5) begin
                mtlo = 1'b1;
                wdata = 32'hBAD0_BAD0;
            end
            tick();
            mtlo = 1'b0;
            if (done === 1'b1) begin
                lat = i;
                break;
            end
            if (i == 6) begin
                vectors++;
                if (hi !== m_hi || lo !== m_lo) begin
                    miscompares++;
                    $display("FAIL %s hilo_frozen: got %h_%h want %h_%h", name, hi, lo, m_hi, m_lo);
                end
            end
        end
        vectors++;
        if (lat != 33) begin
            miscompares++;
            $display("FAIL %s latency: got %0d want 33", name, lat);
        end
        vectors++;
        if (hi !== eh || lo !== el) begin
            miscompares++;
            $display("FAIL %s product: got %h_%h want %h_%h", name, hi, lo, eh, el);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy_in_done: got %b want 0", name, busy);
        end
        m_hi = eh;
        m_lo = el;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        is_signed = 1'b0;
        a = '0;
        b = '0;
        mthi = 1'b0;
        mtlo = 1'b0;
        wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_hilo: got %h_%h want 0_0", hi, lo);
        end
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || dbg_state !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got busy=%b done=%b st=%0d want 0 0 0", busy, done, dbg_state);
        end
        rst_n = 1'b1;
        tick();
        m_hi = 32'h0;
        m_lo = 32'h0;
    endtask

    task automatic test_mthi_mtlo();
        mthi = 1'b1;
        wdata = 32'hDEAD_BEEF;
        tick();
        mthi = 1'b0;
        vectors++;
        if (hi !== 32'hDEAD_BEEF || lo !== 32'h0) begin
            miscompares++;
            $display("FAIL mthi_only: got %h_%h want deadbeef_00000000", hi, lo);
        end
        mthi = 1'b1;
        mtlo = 1'b1;
        wdata = 32'h5;
        tick();
        mthi = 1'b0;
        mtlo = 1'b0;
        vectors++;
        if (hi !== 32'h5 || lo !== 32'h5) begin
            miscompares++;
            $display("FAIL mthi_mtlo_both: got %h_%h want 00000005_00000005", hi, lo);
        end
        m_hi = 32'h5;
        m_lo = 32'h5;
    endtask

    task automatic test_reset_mid_run();
        int dones;
        dones = 0;
        start = 1'b1;
        is_signed = 1'b0;
        a = 32'd3;
        b = 32'd5;
        tick();
        start = 1'b0;
        repeat (9) tick();
        rst_n = 1'b0;
        #1;
        vectors++;
        if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_run: got hi=%h lo=%h busy=%b done=%b want 0 0 0 0", hi, lo, busy, done);
        end
        m_hi = 32'h0;
        m_lo = 32'h0;
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        vectors++;
        if (dones != 0) begin
            miscompares++;
            $display("FAIL reset_no_done: got %0d done pulses want 0", dones);
        end
        run_mul("rerun_3x5", 1'b0, 32'd3, 32'd5, 32'h0, 32'h0000_000F, 0);
    endtask

    task automatic test_unsigned();
        run_mul("multu_ff_ff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
        run_mul("multu_zero", 1'b0, 32'h0, 32'h1234_5678, 32'h0, 32'h0, 0);
    endtask

    task automatic test_signed();
        run_mul("mult_m1_m1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 0);
        run_mul("mult_m2_3", 1'b1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0);
        run_mul("mult_min_min", 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 0);
        run_mul("mult_min_1", 1'b1, 32'h8000_0000, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    endtask

    task automatic test_mtlo_during_run();
        run_mul("mtlo_in_run", 1'b0, 32'h1234_5678, 32'h10, 32'h0000_0001, 32'h2345_6780, 1);
    endtask

    task automatic test_start_mthi_collision();
        run_mul("start_mthi", 1'b0, 32'd2, 32'd3, 32'h0, 32'h6, 3);
    endtask

    task automatic test_back_to_back();
        int lat;
        lat = 0;
        run_mul("b2b_first", 1'b1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 2);
        tick();
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_accept: got busy=%b done=%b want 1 0", busy, done);
        end
        start = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
        vectors++;
        if (lat != 33) begin
            miscompares++;
            $display("FAIL b2b_latency: got %0d want 33", lat);
        end
        vectors++;
        if (hi !== 32'h0 || lo !== 32'd42) begin
            miscompares++;
            $display("FAIL b2b_product: got %h_%h want 00000000_0000002a", hi, lo);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_done_pulse: got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_mthi_mtlo();
        test_reset_mid_run();
        test_unsigned();
        test_signed();
        test_mtlo_during_run();
        test_start_mthi_collision();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
